// File: rtl/ariane_pkg.sv
// Shared constants and types for the hardware performance monitor.
// Overflow interrupt support is enabled by defining HPM_OVERFLOW_IRQ_EN.
package ariane_pkg;

  localparam int unsigned HPM_ADDR_WIDTH = 7;
  localparam int unsigned HPM_DATA_WIDTH = 64;

  localparam logic [HPM_ADDR_WIDTH-1:0] HPM_CNT_BASE   = 7'h00;
  localparam logic [HPM_ADDR_WIDTH-1:0] HPM_SEL_BASE   = 7'h20;
  localparam logic [HPM_ADDR_WIDTH-1:0] HPM_INHIBIT    = 7'h40;
  localparam logic [HPM_ADDR_WIDTH-1:0] HPM_OVF_STATUS = 7'h41;

  // Standard event source indices; selector value is index + 1.
  typedef enum logic [3:0] {
    HPM_EV_ICACHE_MISS = 4'd0,
    HPM_EV_DCACHE_MISS = 4'd1,
    HPM_EV_ITLB_MISS   = 4'd2,
    HPM_EV_DTLB_MISS   = 4'd3,
    HPM_EV_LOAD        = 4'd4,
    HPM_EV_STORE       = 4'd5,
    HPM_EV_BRANCH      = 4'd6,
    HPM_EV_CALL        = 4'd7,
    HPM_EV_RET         = 4'd8,
    HPM_EV_EXCEPTION   = 4'd9,
    HPM_EV_ERET        = 4'd10,
    HPM_EV_MISPREDICT  = 4'd11,
    HPM_EV_SB_FULL     = 4'd12,
    HPM_EV_IF_EMPTY    = 4'd13
  } hpm_event_e;

endpackage

// File: rtl/hpm_counter_slice.sv
// One performance counter: event selector, increment mux, counter and carry-out detect.
// With HPM_OVERFLOW_IRQ_EN defined the slice also exports a per-cycle overflow pulse.
module hpm_counter_slice
  import ariane_pkg::*;
#(
  parameter int unsigned CounterWidth = 64,
  parameter int unsigned NumEvents    = 16,
  parameter int unsigned IncWidth     = 2,
  parameter int unsigned SelWidth     = 5
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
`ifdef HPM_OVERFLOW_IRQ_EN
  output logic                                ovf_c,
`endif
  input  logic                                count_en_i,
  input  logic                                cnt_we_i,
  input  logic                                sel_we_i,
  input  logic [HPM_DATA_WIDTH-1:0]           wdata_i,
  input  logic [NumEvents-1:0][IncWidth-1:0]  event_inc_i,
  output logic [CounterWidth-1:0]             cnt_o,
  output logic [SelWidth-1:0]                 sel_o
);

  logic [CounterWidth-1:0] cnt_q;
  logic [SelWidth-1:0]     sel_q;
  logic [IncWidth-1:0]     inc;

  // Selector 0 and values above NumEvents leave the increment at zero.
  always_comb begin
    inc = '0;
    for (int k = 0; k < int'(NumEvents); k++) begin
      if (sel_q == SelWidth'(k + 1)) inc = event_inc_i[k];
    end
  end

`ifdef HPM_OVERFLOW_IRQ_EN
  logic [CounterWidth:0] sum;
  assign sum   = {1'b0, cnt_q} + (CounterWidth + 1)'(inc);
  // A software write replaces the increment, so it cannot overflow.
  assign ovf_c = count_en_i & ~cnt_we_i & sum[CounterWidth];
`else
  logic [CounterWidth-1:0] sum;
  assign sum = cnt_q + CounterWidth'(inc);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      sel_q <= '0;
    end else begin
      if (cnt_we_i)        cnt_q <= wdata_i[CounterWidth-1:0];
      else if (count_en_i) cnt_q <= sum[CounterWidth-1:0];
      if (sel_we_i)        sel_q <= wdata_i[SelWidth-1:0];
    end
  end

  assign cnt_o = cnt_q;
  assign sel_o = sel_q;

endmodule

// File: rtl/hpm_counters.sv
// Bank of hardware performance counters with register access and optional overflow IRQ.
// Overflow status and irq_o are built only when HPM_OVERFLOW_IRQ_EN is defined.
module hpm_counters
  import ariane_pkg::*;
#(
  parameter int unsigned NumCounters  = 8,
  parameter int unsigned CounterWidth = 64,
  parameter int unsigned NumEvents    = 16,
  parameter int unsigned IncWidth     = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                debug_mode_i,
  input  logic [HPM_ADDR_WIDTH-1:0]           addr_i,
  input  logic                                we_i,
  input  logic [HPM_DATA_WIDTH-1:0]           data_i,
  output logic [HPM_DATA_WIDTH-1:0]           data_o,
  input  logic [NumEvents-1:0][IncWidth-1:0]  event_inc_i,
  output logic                                irq_o
);

  localparam int unsigned SelWidth = $clog2(NumEvents + 1);

  logic [NumCounters-1:0][CounterWidth-1:0] cnt;
  logic [NumCounters-1:0][SelWidth-1:0]     sel;
  logic [NumCounters-1:0]                   inhibit_q;
  logic [NumCounters-1:0]                   count_en;
  logic                                     idx_valid;
  logic                                     in_cnt_range;
  logic                                     in_sel_range;

  assign idx_valid    = {1'b0, addr_i[4:0]} < 6'(NumCounters);
  assign in_cnt_range = (addr_i[6:5] == HPM_CNT_BASE[6:5]) && idx_valid;
  assign in_sel_range = (addr_i[6:5] == HPM_SEL_BASE[6:5]) && idx_valid;
  assign count_en     = ~inhibit_q & {NumCounters{~debug_mode_i}};

`ifdef HPM_OVERFLOW_IRQ_EN
  logic [NumCounters-1:0] ovf_c;
`endif

  for (genvar g = 0; g < int'(NumCounters); g++) begin : g_slice
    hpm_counter_slice #(
      .CounterWidth (CounterWidth),
      .NumEvents    (NumEvents),
      .IncWidth     (IncWidth),
      .SelWidth     (SelWidth)
    ) u_slice (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
`ifdef HPM_OVERFLOW_IRQ_EN
      .ovf_c       (ovf_c[g]),
`endif
      .count_en_i  (count_en[g]),
      .cnt_we_i    (we_i && in_cnt_range && (addr_i[4:0] == 5'(g))),
      .sel_we_i    (we_i && in_sel_range && (addr_i[4:0] == 5'(g))),
      .wdata_i     (data_i),
      .event_inc_i (event_inc_i),
      .cnt_o       (cnt[g]),
      .sel_o       (sel[g])
    );
  end

  // Inhibit mask only has storage for implemented counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                            inhibit_q <= '0;
    else if (we_i && addr_i == HPM_INHIBIT) inhibit_q <= data_i[NumCounters-1:0];
  end

`ifdef HPM_OVERFLOW_IRQ_EN
  logic [NumCounters-1:0] ovf_q;
  logic [NumCounters-1:0] ovf_d;
  logic [NumCounters-1:0] ovf_w1c;
  logic                   irq_q;

  // Write-1-to-clear, with a same-cycle overflow keeping the bit set.
  always_comb begin
    ovf_w1c = '0;
    if (we_i && addr_i == HPM_OVF_STATUS) ovf_w1c = data_i[NumCounters-1:0];
    ovf_d = (ovf_q & ~ovf_w1c) | ovf_c;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= '0;
      irq_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      irq_q <= |ovf_q;
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  // Read mux from registered state only; reads during a write see the old value.
  always_comb begin
    data_o = '0;
    for (int i = 0; i < int'(NumCounters); i++) begin
      if (addr_i[4:0] == 5'(i)) begin
        if (in_cnt_range) data_o = HPM_DATA_WIDTH'(cnt[i]);
        if (in_sel_range) data_o = HPM_DATA_WIDTH'(sel[i]);
      end
    end
    if (addr_i == HPM_INHIBIT) data_o = HPM_DATA_WIDTH'(inhibit_q);
`ifdef HPM_OVERFLOW_IRQ_EN
    if (addr_i == HPM_OVF_STATUS) data_o = HPM_DATA_WIDTH'(ovf_q);
`endif
  end

endmodule

// File: tb/tb_hpm_counters.sv
// Self-checking bench for hpm_counters: register-level model compared every cycle,
// plus directed scenarios with hand-computed expected values.
module tb_hpm_counters;

  localparam int unsigned NC = 8;
  localparam int unsigned CW = 64;
  localparam int unsigned NE = 16;
  localparam int unsigned IW = 2;
  localparam int unsigned SW = $clog2(NE + 1);

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic                   debug_mode_i;
  logic [6:0]             addr_i;
  logic                   we_i;
  logic [63:0]            data_i;
  logic [63:0]            data_o;
  logic [NE-1:0][IW-1:0]  event_inc_i;
  logic                   irq_o;

  int checks   = 0;
  int failures = 0;

  hpm_counters #(
    .NumCounters  (NC),
    .CounterWidth (CW),
    .NumEvents    (NE),
    .IncWidth     (IW)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .debug_mode_i (debug_mode_i),
    .addr_i       (addr_i),
    .we_i         (we_i),
    .data_i       (data_i),
    .data_o       (data_o),
    .event_inc_i  (event_inc_i),
    .irq_o        (irq_o)
  );

  always #5 clk_i = ~clk_i;

  // Architectural model of the register file.
  logic [CW-1:0] m_cnt [NC];
  logic [SW-1:0] m_sel [NC];
  logic [NC-1:0] m_inh;
  logic [NC-1:0] m_ovf;
  logic          m_irq;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NC; i++) begin
        m_cnt[i] = '0;
        m_sel[i] = '0;
      end
      m_inh = '0;
      m_ovf = '0;
      m_irq = 1'b0;
    end else begin
      logic [NC-1:0] ovf_now;
      logic [NC-1:0] clr;
      logic [CW:0]   s;
      int            k;
      logic [IW-1:0] inc;
      ovf_now = '0;
      for (int i = 0; i < NC; i++) begin
        k   = int'(m_sel[i]);
        inc = (k >= 1 && k <= NE) ? event_inc_i[k-1] : '0;
        if (we_i && int'(addr_i) == i) begin
          m_cnt[i] = data_i[CW-1:0];
        end else if (!debug_mode_i && !m_inh[i]) begin
          s          = {1'b0, m_cnt[i]} + (CW + 1)'(inc);
          m_cnt[i]   = s[CW-1:0];
          ovf_now[i] = s[CW];
        end
        if (we_i && int'(addr_i) == 32 + i) m_sel[i] = data_i[SW-1:0];
      end
      if (we_i && addr_i == 7'h40) m_inh = data_i[NC-1:0];
`ifdef HPM_OVERFLOW_IRQ_EN
      m_irq = (m_ovf != '0);
      clr   = (we_i && addr_i == 7'h41) ? data_i[NC-1:0] : '0;
      m_ovf = (m_ovf & ~clr) | ovf_now;
`else
      clr = '0;
`endif
    end
  end

  function automatic logic [63:0] exp_read(input logic [6:0] a);
    int ia = int'(a);
    if (ia < 32)                return (ia < NC) ? 64'(m_cnt[ia]) : 64'd0;
    if (ia < 64)                return (ia - 32 < NC) ? 64'(m_sel[ia-32]) : 64'd0;
    if (a == 7'h40)             return 64'(m_inh);
`ifdef HPM_OVERFLOW_IRQ_EN
    if (a == 7'h41)             return 64'(m_ovf);
`endif
    return 64'd0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Continuous comparison against the model.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1) begin
      chk("model_data_o", data_o, exp_read(addr_i));
      chk("model_irq_o", 64'(irq_o), 64'(m_irq));
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [6:0] a, input logic [63:0] d);
    addr_i = a;
    data_i = d;
    we_i   = 1'b1;
    step();
    we_i   = 1'b0;
    data_i = '0;
  endtask

  task automatic lit(input string name, input logic [6:0] a, input logic [63:0] req);
    addr_i = a;
    #1;
    chk(name, data_o, req);
  endtask

  logic [6:0] unmapped [7];

  initial begin
    unmapped[0] = 7'h08; unmapped[1] = 7'h1F; unmapped[2] = 7'h28; unmapped[3] = 7'h3F;
    unmapped[4] = 7'h42; unmapped[5] = 7'h60; unmapped[6] = 7'h7F;
    rst_ni       = 1'b0;
    debug_mode_i = 1'b0;
    addr_i       = '0;
    we_i         = 1'b0;
    data_i       = '0;
    event_inc_i  = '0;

    // Reset state
    #12;
    lit("reset_cnt0", 7'h00, 64'd0);
    lit("reset_sel0", 7'h20, 64'd0);
    lit("reset_inh", 7'h40, 64'd0);
    chk("reset_irq", 64'(irq_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();

    // Event 3 with increment 2 for ten cycles
    wr(7'h20, 64'd4);
    event_inc_i[3] = 2'd2;
    repeat (10) step();
    event_inc_i = '0;
    lit("ev3_x10", 7'h00, 64'd20);

    // Counter 1 wraps from all-ones
    wr(7'h01, {64{1'b1}});
    wr(7'h21, 64'd1);
    event_inc_i[0] = 2'd1;
    step();
    event_inc_i = '0;
    lit("wrap_cnt1", 7'h01, 64'd0);
`ifdef HPM_OVERFLOW_IRQ_EN
    lit("ovf_status", 7'h41, 64'h2);
    chk("irq_not_yet", 64'(irq_o), 64'd0);
    step();
    chk("irq_set", 64'(irq_o), 64'd1);
    wr(7'h41, 64'h2);
    lit("ovf_cleared", 7'h41, 64'd0);
    step();
    chk("irq_cleared", 64'(irq_o), 64'd0);
`else
    lit("ovf_status_off", 7'h41, 64'd0);
    step();
    chk("irq_tied", 64'(irq_o), 64'd0);
`endif

    // Write beats increment; read during write returns old value
    wr(7'h22, 64'd2);
    event_inc_i[1] = 2'd3;
    step();
    addr_i = 7'h02;
    data_i = 64'd100;
    we_i   = 1'b1;
    #1;
    chk("read_during_write", data_o, 64'd3);
    step();
    we_i = 1'b0;
    event_inc_i = '0;
    lit("write_wins", 7'h02, 64'd100);

    // Inhibit and debug hold the counter
    wr(7'h40, 64'd1);
    event_inc_i[3] = 2'd1;
    repeat (5) step();
    lit("inhibit_hold", 7'h00, 64'd20);
    wr(7'h40, 64'd0);
    lit("inhibit_edge", 7'h00, 64'd20);
    step();
    lit("inhibit_resume", 7'h00, 64'd21);
    debug_mode_i = 1'b1;
    repeat (4) step();
    wr(7'h03, 64'd7);
    lit("debug_hold", 7'h00, 64'd21);
    lit("debug_write", 7'h03, 64'd7);
    debug_mode_i = 1'b0;
    step();
    event_inc_i = '0;
    lit("debug_resume", 7'h00, 64'd22);

    // Selector above NumEvents counts nothing
    wr(7'h23, 64'(NE + 1));
    event_inc_i = '1;
    repeat (3) step();
    event_inc_i = '0;
    lit("sel_off", 7'h03, 64'd7);

    // Unmapped addresses read zero and ignore writes
    for (int i = 0; i < 7; i++) wr(unmapped[i], 64'h55);
    for (int i = 0; i < 7; i++) lit("unmapped_read", unmapped[i], 64'd0);
    step();
    wr(7'h40, {64{1'b1}});
    lit("inhibit_width", 7'h40, 64'hFF);
    wr(7'h40, 64'd0);

    // Selector truncation and shared events
    wr(7'h24, 64'hFFFF_FFFF_FFFF_FFE3);
    lit("sel_trunc", 7'h24, 64'd3);
    wr(7'h25, 64'd3);
    event_inc_i[2] = 2'd1;
    repeat (4) step();
    event_inc_i = '0;
    lit("shared_c4", 7'h04, 64'd4);
    lit("shared_c5", 7'h05, 64'd4);

    // Asynchronous reset mid-count
    event_inc_i = '1;
    repeat (2) step();
    #2;
    rst_ni = 1'b0;
    #1;
    lit("arst_cnt0", 7'h00, 64'd0);
    lit("arst_cnt4", 7'h04, 64'd0);
    lit("arst_sel0", 7'h20, 64'd0);
    chk("arst_irq", 64'(irq_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) step();
    lit("post_reset_idle", 7'h00, 64'd0);
    wr(7'h20, 64'd1);
    step();
    event_inc_i = '0;
    lit("post_reset_count", 7'h00, 64'd3);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hpm_counters.md
HPM_COUNTERS -- requirements
Module: hpm_counters

Interface
REQ-001 SHALL have parameter NumCounters, default 8, number of event counters (1..32).
REQ-002 SHALL have parameter CounterWidth, default 64, counter bit width (32..64).
REQ-003 SHALL have parameter NumEvents, default 16, number of event sources (1..31).
REQ-004 SHALL have parameter IncWidth, default 2, width of per-event increment (max NR_COMMIT_PORTS).
REQ-005 SHALL have port clk_i, input, 1, clock; one clock domain only.
REQ-006 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port debug_mode_i, input, 1, core in debug mode.
REQ-008 SHALL have port addr_i, input, 7, register address.
REQ-009 SHALL have port we_i, input, 1, write enable.
REQ-010 SHALL have port data_i, input, 64, write data.
REQ-011 SHALL have port data_o, output, 64, read data.
REQ-012 SHALL have port event_inc_i, input, NumEvents x IncWidth, per-cycle increment amount per event.
REQ-013 SHALL have port irq_o, output, 1, counter overflow interrupt.

Function
REQ-014 SHALL use this address map: 0x00+i = counter i; 0x20+i = event selector i; 0x40 = inhibit mask; 0x41 = overflow status.
REQ-015 SHALL make selector i $clog2(NumEvents+1) bits wide: value 0 means off; value k in 1..NumEvents selects event_inc_i[k-1]; values above NumEvents mean off.
REQ-016 SHALL, each cycle with debug_mode_i=0 and inhibit bit i=0, add the selected increment (zero-extended) to counter i.
REQ-017 SHALL add arithmetic modulo 2^CounterWidth; a carry out of the MSB is an overflow of counter i.
REQ-018 SHALL hold all counters while debug_mode_i=1, with register writes still accepted.
REQ-019 SHALL drive data_o combinationally from the registered (_q) value at addr_i, so a read during a write returns the old value.
REQ-020 SHALL zero-extend reads of narrower registers to 64 bits.
REQ-021 SHALL read 0 and ignore writes for unmapped addresses and for counters/selectors with index >= NumCounters.
REQ-022 SHALL update a register written with we_i=1 at the next clock edge, truncated to register width.
REQ-023 SHALL give a write to counter i precedence over that counter's increment in the same cycle; the increment is lost.
REQ-024 SHALL let several counters select the same event; each counts independently.
REQ-025 SHALL keep inhibit mask bits >= NumCounters at 0.

Reset
REQ-026 SHALL asynchronously clear, on rst_ni=0, all counters, selectors, the inhibit mask, overflow status and irq_o.
REQ-027 SHALL resume counting on the first clock edge after rst_ni deasserts.

Configuration
REQ-028 SHALL implement the following only when HPM_OVERFLOW_IRQ_EN is defined: on overflow of counter i, set sticky overflow status bit i; irq_o = registered OR of status bits.
REQ-029 SHALL clear status bit i when 1 is written to bit i of address 0x41 (write-1-to-clear); an overflow in the same cycle wins and the bit stays set.
REQ-030 SHALL, when HPM_OVERFLOW_IRQ_EN is not defined, tie irq_o to 0, read 0 at 0x41, ignore writes there, and build no status flops.

Structure
REQ-031 SHALL place in ariane_pkg the address constants HPM_CNT_BASE, HPM_SEL_BASE, HPM_INHIBIT and HPM_OVF_STATUS, plus an hpm_event_e enum of standard event indices (icache miss, dcache miss, itlb miss, dtlb miss, load, store, branch, call, ret, exception, eret, mispredict, sb full, if empty).
REQ-032 SHALL instantiate one sub-module hpm_counter_slice per counter, holding the counter, selector, increment mux and overflow detect.

Verification
REQ-033 SHALL cover: select event 3 on counter 0 (sel0=4), drive event_inc_i[3]=2 for 10 cycles, then read 0x00 = 20.
REQ-034 SHALL cover: write counter 1 = 2^CounterWidth-1, select an event with increment 1 for 1 cycle -> counter 1 = 0; with HPM_OVERFLOW_IRQ_EN, 0x41 bit1=1 and irq_o=1 one cycle later; write 0x41=0x2 -> irq_o=0.
REQ-035 SHALL cover: write counter 2 = 100 in the same cycle as an increment of 3 -> counter 2 = 100; a read in that cycle returns the old value.
REQ-036 SHALL cover: set inhibit bit 0 or debug_mode_i=1 with an active event for 5 cycles -> counter unchanged; clear both -> counting resumes the next cycle.
REQ-037 SHALL cover: sel=NumEvents+1 or an unmapped address -> no counting, data_o=0; assert rst_ni mid-count -> all registers 0 immediately, without waiting for a clock.
